load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the data and address width, taken from the shared utils package.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port ex_valid, input, 1, EX stage presents a memory op.
REQ-005 SHALL have port ex_ready, output, 1, unit accepts the op (high only in IDLE).
REQ-006 SHALL have port ex_is_store, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port ex_funct3, input, 3, RV64I width/sign code (LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD).
REQ-008 SHALL have ports ex_addr, input, DATA_WIDTH, effective byte address; ex_wdata, input, DATA_WIDTH, store data in low bits; ex_rd, input, 5, destination register.
REQ-009 SHALL have ports mem_req_valid, output, 1; mem_req_ready, input, 1; mem_req_we, output, 1; mem_req_addr, output, DATA_WIDTH, 8-byte aligned; mem_req_wdata, output, DATA_WIDTH; mem_req_wstrb, output, 8, byte enables.
REQ-010 SHALL have ports mem_resp_valid, input, 1, read data or write ack; mem_resp_rdata, input, DATA_WIDTH.
REQ-011 SHALL have ports wb_valid, output, 1; wb_ready, input, 1; wb_we, output, 1, register write enable; wb_rd, output, 5; wb_data, output, DATA_WIDTH; wb_misaligned, output, 1, address-misaligned exception.

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE; IDLE -> RESP directly for misaligned ops.
REQ-013 SHALL in IDLE, on ex_valid, capture op, funct3, addr, wdata, rd into registers.
REQ-014 SHALL flag misaligned when addr[0]!=0 for H, addr[1:0]!=0 for W, addr[2:0]!=0 for D; B never misaligned.
REQ-015 SHALL in REQ hold mem_req_valid high and all mem_req_* stable until mem_req_ready; handshake -> WAIT.
REQ-016 SHALL drive mem_req_addr = {addr[63:3],3'b000}; wstrb = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) shifted left by addr[2:0]; wdata = ex_wdata shifted left by 8*addr[2:0]; loads drive wstrb 0, we 0.
REQ-017 SHALL in WAIT, on mem_resp_valid, shift rdata right by 8*addr[2:0], extend per funct3 using the package sext_8/16/32, zext_8/16/32 functions (D passes through), register result -> RESP.
REQ-018 SHALL in RESP hold wb_valid high, outputs stable, until wb_ready; handshake -> IDLE.
REQ-019 SHALL set wb_we=1 only for aligned loads with rd!=0; stores and misaligned ops wb_we=0; wb_misaligned=1 only for misaligned ops, with wb_data = faulting address.
REQ-020 SHALL ignore mem_resp_valid outside WAIT and ex_valid outside IDLE.
REQ-021 SHALL issue no memory request for a misaligned op.
REQ-022 SHALL accept a new op no earlier than the cycle after the wb handshake; minimum aligned latency accept->wb_valid = 3 cycles with zero-wait memory.
REQ-023 SHALL accept an invalid funct3 (e.g. 3'b111 load) as LD-width behaviour-free: treated as misaligned exception.

Reset
REQ-024 SHALL on rst_n low force state IDLE and drive ex_ready=1 (after reset), mem_req_valid=0, mem_req_we=0, mem_req_wstrb=0, wb_valid=0, wb_we=0, wb_misaligned=0, wb_rd=0, wb_data=0, mem_req_addr=0, mem_req_wdata=0.
REQ-025 SHALL abandon any in-flight op on reset mid-WAIT; late mem_resp_valid after reset SHALL be ignored.

Structure
REQ-026 SHALL place the FSM state enum and funct3 width constants in the shared utils package alongside existing extension functions.
REQ-027 SHALL factor load alignment/extension into one combinational sub-module, load_align, reused nowhere else.

Verification
REQ-028 LB addr 0x1003, rdata byte3=0x80 -> mem_req_addr 0x1000, wb_data 0xFFFFFFFFFFFFFF80, wb_we=1.
REQ-029 LWU addr 0x1004, rdata 0x89ABCDEF_00000000 -> wb_data 0x0000000089ABCDEF.
REQ-030 SH addr 0x1006, wdata 0xBEEF -> wstrb 0xC0, mem_req_wdata 0xBEEF000000000000, wb_we=0.
REQ-031 LW addr 0x1002 -> no mem_req_valid, wb_misaligned=1, wb_data 0x1002.
REQ-032 mem_req_ready low 4 cycles then wb_ready low 3 cycles -> request and wb outputs stable throughout, ex_ready=0.
REQ-033 rst_n low during WAIT, then stray mem_resp_valid -> wb_valid stays 0, ex_ready=1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared types, width codes and extension helpers for the load/store unit
package load_store_unit_pkg;

   localparam int XLEN = 64;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   function automatic logic [63:0] sext_8(input logic [7:0] v);
      return {{56{v[7]}}, v};
   endfunction

   function automatic logic [63:0] sext_16(input logic [15:0] v);
      return {{48{v[15]}}, v};
   endfunction

   function automatic logic [63:0] sext_32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] zext_8(input logic [7:0] v);
      return {56'd0, v};
   endfunction

   function automatic logic [63:0] zext_16(input logic [15:0] v);
      return {48'd0, v};
   endfunction

   function automatic logic [63:0] zext_32(input logic [31:0] v);
      return {32'd0, v};
   endfunction

   // byte-enable pattern for an access size before shifting into the lane
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
   endfunction

   // undefined width codes raise the same exception as a misaligned address
   function automatic logic misaligned_op(input logic is_store, input logic [2:0] f3, input logic [2:0] lo);
      logic bad_f3;
      logic bad_lo;
      bad_f3 = is_store ? f3[2] : (f3 == 3'b111);
      bad_lo = f3[1:0] == SZ_H ? lo[0] : f3[1:0] == SZ_W ? |lo[1:0] : f3[1:0] == SZ_D ? |lo : 1'b0;
      return bad_f3 | bad_lo;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: moves the addressed lane of a memory word down to bit 0 and extends it
module load_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN
) (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [2:0]            offset,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] lane;

   assign lane = rdata >> {offset, 3'b000};

   // pick signed or unsigned extension by width code; doubleword passes through
   always_comb begin
      data = funct3 == F3_B  ? sext_8(lane[7:0])   :
             funct3 == F3_H  ? sext_16(lane[15:0]) :
             funct3 == F3_W  ? sext_32(lane[31:0]) :
             funct3 == F3_BU ? zext_8(lane[7:0])   :
             funct3 == F3_HU ? zext_16(lane[15:0]) :
             funct3 == F3_WU ? zext_32(lane[31:0]) : lane;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV64I load/store engine between EX, memory and writeback
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  ex_is_store,
   input  logic [2:0]            ex_funct3,
   input  logic [DATA_WIDTH-1:0] ex_addr,
   input  logic [DATA_WIDTH-1:0] ex_wdata,
   input  logic [4:0]            ex_rd,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_we,
   output logic [DATA_WIDTH-1:0] mem_req_addr,
   output logic [DATA_WIDTH-1:0] mem_req_wdata,
   output logic [7:0]            mem_req_wstrb,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_we,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_misaligned
);

   lsu_state_e            state;
   logic                  op_store;
   logic [2:0]            op_f3;
   logic [2:0]            op_off;
   logic                  ex_misaligned;
   logic [7:0]            ex_wstrb;
   logic [DATA_WIDTH-1:0] load_data;

   assign ex_misaligned = misaligned_op(ex_is_store, ex_funct3, ex_addr[2:0]);
   assign ex_wstrb      = size_mask(ex_funct3[1:0]) << ex_addr[2:0];

   load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
      .rdata (mem_resp_rdata),
      .offset(op_off),
      .funct3(op_f3),
      .data  (load_data)
   );

   // sequencer: all handshake and payload outputs are registered so they stay stable while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         ex_ready      <= 1'b1;
         op_store      <= 1'b0;
         op_f3         <= 3'd0;
         op_off        <= 3'd0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= 8'h00;
         wb_valid      <= 1'b0;
         wb_we         <= 1'b0;
         wb_rd         <= 5'd0;
         wb_data       <= '0;
         wb_misaligned <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (ex_valid) begin
               ex_ready <= 1'b0;
               op_store <= ex_is_store;
               op_f3    <= ex_funct3;
               op_off   <= ex_addr[2:0];
               wb_rd    <= ex_rd;
               if (ex_misaligned) begin
                  state         <= S_RESP;
                  wb_valid      <= 1'b1;
                  wb_we         <= 1'b0;
                  wb_misaligned <= 1'b1;
                  wb_data       <= ex_addr;
               end else begin
                  state         <= S_REQ;
                  mem_req_valid <= 1'b1;
                  mem_req_we    <= ex_is_store;
                  mem_req_addr  <= {ex_addr[DATA_WIDTH-1:3], 3'b000};
                  mem_req_wdata <= ex_is_store ? ex_wdata << {ex_addr[2:0], 3'b000} : '0;
                  mem_req_wstrb <= ex_is_store ? ex_wstrb : 8'h00;
               end
            end
            S_REQ: if (mem_req_ready) begin
               state         <= S_WAIT;
               mem_req_valid <= 1'b0;
            end
            S_WAIT: if (mem_resp_valid) begin
               state         <= S_RESP;
               wb_valid      <= 1'b1;
               wb_misaligned <= 1'b0;
               wb_we         <= !op_store && wb_rd != 5'd0;
               wb_data       <= op_store ? '0 : load_data;
            end
            S_RESP: if (wb_ready) begin
               state    <= S_IDLE;
               wb_valid <= 1'b0;
               ex_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
